// File: rtl/fpu_issue_ctrl.sv
// Issue/return controller for fixed-latency, handshake-free FPU units.
// Define FPU_RSP_BYPASS_EN to present a result on rsp_* in the cycle it leaves the unit.
module fpu_issue_ctrl #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_x1,
    input  logic [31:0]     req_x2,
    input  logic [TAGW-1:0] req_tag,
    output logic [31:0]     fu_x1,
    output logic [31:0]     fu_x2,
    input  logic [31:0]     fu_y,
    input  logic            fu_ovf,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_y,
    output logic            rsp_ovf,
    output logic [TAGW-1:0] rsp_tag,
    output logic            busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(2 * DEPTH + 1);
    localparam int EW = 33 + TAGW;

    logic                fire;
    logic [LATENCY:1]    pv_reg;
    logic [TAGW-1:0]     ptag_reg [1:LATENCY];
    logic [SW-1:0]       inflight;
    logic [EW-1:0]       mem_reg [DEPTH];
    logic [EW-1:0]       head;
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic [CW-1:0]       count_next;
    logic                fifo_nonempty;
    logic                wr_en;
    logic                pop;

    assign fu_x1 = req_x1;
    assign fu_x2 = req_x2;
    assign fire  = req_valid & req_ready;

    // Slot chain mirrors the unit pipeline so each result is matched to its tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv_reg[1]   <= 1'b0;
            ptag_reg[1] <= '0;
        end else begin
            pv_reg[1]   <= fire;
            ptag_reg[1] <= req_tag;
        end
    end

    generate
        for (genvar gi = 2; gi <= LATENCY; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    pv_reg[gi]   <= 1'b0;
                    ptag_reg[gi] <= '0;
                end else begin
                    pv_reg[gi]   <= pv_reg[gi-1];
                    ptag_reg[gi] <= ptag_reg[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            inflight = inflight + SW'(pv_reg[k]);
        end
    end

    // Credit counts slots already in flight so every returning result has room.
    assign req_ready     = (inflight + SW'(count_reg)) < SW'(DEPTH);
    assign fifo_nonempty = (count_reg != '0);
    assign busy          = (inflight != '0) | fifo_nonempty;
    assign head          = mem_reg[rd_ptr_reg];
    assign pop           = fifo_nonempty & rsp_ready;

`ifdef FPU_RSP_BYPASS_EN
    logic bypass;
    assign bypass    = ~fifo_nonempty & pv_reg[LATENCY];
    assign wr_en     = pv_reg[LATENCY] & ~(bypass & rsp_ready);
    assign rsp_valid = fifo_nonempty | bypass;
    assign rsp_y     = bypass ? fu_y : (fifo_nonempty ? head[31:0] : 32'd0);
    assign rsp_ovf   = bypass ? fu_ovf : (fifo_nonempty & head[32]);
    assign rsp_tag   = bypass ? ptag_reg[LATENCY]
                              : (fifo_nonempty ? head[EW-1:33] : '0);
`else
    assign wr_en     = pv_reg[LATENCY];
    assign rsp_valid = fifo_nonempty;
    // Gate the head so stale array contents never show while empty.
    assign rsp_y     = fifo_nonempty ? head[31:0] : 32'd0;
    assign rsp_ovf   = fifo_nonempty & head[32];
    assign rsp_tag   = fifo_nonempty ? head[EW-1:33] : '0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= {ptag_reg[LATENCY], fu_ovf, fu_y};
        end
    end

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!wr_en && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule
